// File: rtl/v_irq_pkg.sv
// Shared constants and VICVectCntl field helpers for the vectored IRQ slot.
// Optional source-index output is enabled with VIRQ_SRC_OUT_EN.
package v_irq_pkg;

    localparam int VIRQ_EN_BIT      = 5;
    localparam int VIRQ_SRC_W       = 5;
    localparam int VIRQ_NUM_SRC_MAX = 32;

    function automatic logic vect_cntl_en(input logic [31:0] word);
        return word[VIRQ_EN_BIT];
    endfunction

    function automatic logic [VIRQ_SRC_W-1:0] vect_cntl_src(
        input logic [31:0] word
    );
        return word[VIRQ_SRC_W-1:0];
    endfunction

endpackage

// File: rtl/v_irq_if.sv
// Control/status/request bundle of one vectored IRQ slot.
// vIRQSrc exists only when VIRQ_SRC_OUT_EN is defined.
interface v_irq_if;
    import v_irq_pkg::*;

    logic [31:0]           top_reg_VICVectCntlx;
    logic [31:0]           IRQStatus;
    logic                  vIRQRequest;
`ifdef VIRQ_SRC_OUT_EN
    logic [VIRQ_SRC_W-1:0] vIRQSrc;
`endif

`ifdef VIRQ_SRC_OUT_EN
    modport master (
        output top_reg_VICVectCntlx,
        output IRQStatus,
        input  vIRQRequest,
        input  vIRQSrc
    );
    modport slave (
        input  top_reg_VICVectCntlx,
        input  IRQStatus,
        output vIRQRequest,
        output vIRQSrc
    );
`else
    modport master (
        output top_reg_VICVectCntlx,
        output IRQStatus,
        input  vIRQRequest
    );
    modport slave (
        input  top_reg_VICVectCntlx,
        input  IRQStatus,
        output vIRQRequest
    );
`endif

endinterface

// File: rtl/v_irq_src_sel.sv
// Status-bit mux: picks IRQStatus[src_idx], 0 for unimplemented sources.
// Only the addressed bit is read, so X on other bits cannot leak through.
module v_irq_src_sel
    import v_irq_pkg::*;
#(
    parameter int NUM_SRC = VIRQ_NUM_SRC_MAX,
    parameter int SRC_W   = VIRQ_SRC_W
) (
    input  logic [SRC_W-1:0]            src_idx,
    input  logic [VIRQ_NUM_SRC_MAX-1:0] status,
    output logic                        sel
);

    always_comb begin
        sel = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_idx == SRC_W'(i)) begin
                sel = status[i];
            end
        end
    end

endmodule

// File: rtl/v_irq_unit.sv
// One vectored IRQ slot: enable-gated source select, registered request.
// Define VIRQ_SRC_OUT_EN to also register the active source index.
module v_irq_unit
    import v_irq_pkg::*;
#(
    parameter int NUM_SRC = VIRQ_NUM_SRC_MAX,
    parameter int SRC_W   = VIRQ_SRC_W
) (
    input  logic    clk,
    input  logic    rst_n,
    v_irq_if.slave  irq
);

    logic [SRC_W-1:0] src_idx;
    logic             src_sel;
    logic             req_d;
    logic             req_q;
    logic             unused_ctrl_hi;

    assign src_idx        = vect_cntl_src(irq.top_reg_VICVectCntlx);
    assign unused_ctrl_hi = ^irq.top_reg_VICVectCntlx[31:6];

    v_irq_src_sel #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_src_sel (
        .src_idx (src_idx),
        .status  (irq.IRQStatus),
        .sel     (src_sel)
    );

    always_comb begin
        req_d = vect_cntl_en(irq.top_reg_VICVectCntlx) & src_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    assign irq.vIRQRequest = req_q;

`ifdef VIRQ_SRC_OUT_EN
    logic [SRC_W-1:0] src_d;
    logic [SRC_W-1:0] src_q;

    always_comb begin
        src_d = '0;
        if (req_d) begin
            src_d = src_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
        end else begin
            src_q <= src_d;
        end
    end

    assign irq.vIRQSrc = src_q;
`endif

endmodule

// File: tb/tb_v_irq_unit.sv
// Directed table-driven bench for v_irq_unit plus reset corner sequences.
// vIRQSrc checks are compiled in when VIRQ_SRC_OUT_EN is defined.
module tb_v_irq_unit;

    logic clk;
    logic rst_n;

    v_irq_if bus ();

    v_irq_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] status;
        logic        exp_req;
        logic [4:0]  exp_src;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_src(input string name, input logic [4:0] exp);
`ifdef VIRQ_SRC_OUT_EN
        chk(name, {27'd0, bus.vIRQSrc}, {27'd0, exp});
`else
        if (exp === 5'bx) $display("unreachable");
`endif
    endtask

    vec_t vecs[14];
    logic prev_req;
    logic [31:0] xstat;

    initial begin
        xstat    = 32'hxxxx_xxxx;
        xstat[1] = 1'b1;

        vecs[0]  = '{32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 5'd0};
        vecs[1]  = '{32'h0000_0021, 32'hAAAA_AAAA, 1'b1, 5'd1};
        vecs[2]  = '{32'h0000_0020, 32'hAAAA_AAAA, 1'b0, 5'd0};
        vecs[3]  = '{32'h0000_002A, 32'hAAAA_AAAA, 1'b0, 5'd0};
        vecs[4]  = '{32'h0000_002A, 32'hFFFF_FFFF, 1'b1, 5'd10};
        vecs[5]  = '{32'h0000_000A, 32'hFFFF_FFFF, 1'b0, 5'd0};
        vecs[6]  = '{32'hFFFF_FFE1, 32'hFFFF_FFFF, 1'b1, 5'd1};
        vecs[7]  = '{32'hFFFF_FFC1, 32'hFFFF_FFFF, 1'b0, 5'd0};
        vecs[8]  = '{32'h0000_003F, 32'h8000_0000, 1'b1, 5'd31};
        vecs[9]  = '{32'h0000_003F, 32'h7FFF_FFFF, 1'b0, 5'd0};
        vecs[10] = '{32'h0000_0020, 32'h0000_0001, 1'b1, 5'd0};
        vecs[11] = '{32'h0000_0020, 32'h0000_0000, 1'b0, 5'd0};
        vecs[12] = '{32'h0000_0023, 32'h0000_0008, 1'b1, 5'd3};
        vecs[13] = '{32'h0000_0021, xstat,         1'b1, 5'd1};

        // Reset held across edges with everything asserted.
        rst_n = 1'b0;
        bus.top_reg_VICVectCntlx = 32'h0000_0000;
        bus.IRQStatus            = 32'hFFFF_FFFF;
        #1;
        chk("reset_req0", {31'd0, bus.vIRQRequest}, 32'd0);
        chk_src("reset_src0", 5'd0);
        bus.top_reg_VICVectCntlx = 32'h0000_0020;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_held", {31'd0, bus.vIRQRequest}, 32'd0);
        @(negedge clk);
        bus.top_reg_VICVectCntlx = 32'h0000_0000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", {31'd0, bus.vIRQRequest}, 32'd0);

        prev_req = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.top_reg_VICVectCntlx = vecs[i].ctrl;
            bus.IRQStatus            = vecs[i].status;
            #1;
            chk($sformatf("hold_%0d", i), {31'd0, bus.vIRQRequest},
                {31'd0, prev_req});
            @(posedge clk);
            #1;
            chk($sformatf("req_%0d", i), {31'd0, bus.vIRQRequest},
                {31'd0, vecs[i].exp_req});
            chk_src($sformatf("src_%0d", i), vecs[i].exp_src);
            prev_req = vecs[i].exp_req;
        end

        // Asynchronous reset mid-cycle while requesting.
        @(negedge clk);
        bus.top_reg_VICVectCntlx = 32'h0000_0020;
        bus.IRQStatus            = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("pre_async_req", {31'd0, bus.vIRQRequest}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clear_req", {31'd0, bus.vIRQRequest}, 32'd0);
        chk_src("async_clear_src", 5'd0);
        @(posedge clk);
        #1;
        chk("async_hold_req", {31'd0, bus.vIRQRequest}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_no_edge", {31'd0, bus.vIRQRequest}, 32'd0);
        @(posedge clk);
        #1;
        chk("release_first_edge", {31'd0, bus.vIRQRequest}, 32'd1);
        chk_src("release_src", 5'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
